ts_packet_arbiter: RTL and testbench
====================================

Name: ts_packet_arbiter

Overview:
- Packet-atomic scheduler that shares the tx modulator's single TS byte input between two transport-stream sources.
- Grants whole 188-byte packets round-robin, discards bytes that are not aligned to a packet start, and inserts DVB null packets (PID 0x1FFF) when both sources are starved. This keeps the modulator fed at a constant rate.
- Sits between the TS sources (tspattern or external capture) and the tx block, in the tx_ref_clk domain.

Parameters:
- PKT_LEN, 188, bytes per TS packet, including the 0x47 sync byte.
- NULL_WAIT, 16, consecutive idle cycles with irdy=1 and no startable source before a null packet is inserted.
- NULL_EN, 1, 1 enables null insertion; 0 means the arbiter waits indefinitely.

Ports:
- iclk  in  1  clock (tx_ref_clk).
- irst  in  1  asynchronous reset, active-high.
- idat0  in  8  source 0 byte.
- isop0  in  1  source 0 start of packet.
- ival0  in  1  source 0 byte valid.
- ordy0  out  1  source 0 ready; a byte transfers when ival0&ordy0.
- idat1, isop1, ival1, ordy1: same as source 0, for source 1.
- odat  out  8  byte to tx idat.
- osop  out  1  start of packet to tx isop.
- oval  out  1  valid to tx ival.
- irdy  in  1  tx ordy; an output byte transfers when oval&irdy.
- ogrant  out  2  current owner: 0 = idle, 1 = src0, 2 = src1, 3 = null.
- oerr  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (async assert, sync release): state IDLE; byte counter 0; round-robin pointer set to src0; idle counter 0. Outputs after reset: odat=0, osop=0, oval=0, ordy0=0, ordy1=0, ogrant=0, oerr=0.
- States: IDLE, SRC0, SRC1, NULL. Transitions are evaluated on the iclk edge.
- IDLE:
  - A source is startable when ivalN&isopN.
  - Both startable: grant the source selected by the pointer.
  - One startable: grant that source.
  - ivalN&!isopN: assert ordyN and discard the byte (resync flush). Flushed bytes are not counted as errors.
  - Idle counter: increments each cycle with no startable source and irdy=1; clears otherwise.
  - If NULL_EN and the idle counter reaches NULL_WAIT-1 → go to NULL.
  - oval=0.
- SRC0 / SRC1:
  - Combinational pass-through, zero latency: odat=idatN, oval=ivalN, osop=isopN&(cnt==0), ordyN=irdy. The non-granted source has ordy=0.
  - cnt increments on each transfer.
  - When the transfer with cnt==PKT_LEN-1 completes: go to IDLE, cnt←0, pointer←other source.
  - isopN while cnt!=0: the byte is still forwarded with osop=0, and oerr pulses on the cycle after the transfer. The packet length is not changed.
- NULL:
  - Bytes are generated from cnt: cnt0=0x47, cnt1=0x1F, cnt2=0xFF, cnt3=0x10, cnt4..187=0xFF.
  - oval=1; osop=(cnt==0); ordy0=ordy1=0.
  - After the last byte transfers → IDLE. The pointer is unchanged.
- Backpressure: irdy=0 holds cnt and state, and ordyN=0. In NULL, odat is held stable while oval=1 and irdy=0.
- Grant is never pre-empted mid-packet. A request arriving during a null packet waits for that packet to end.
- A source dropping ival mid-packet stalls the output (oval=0). No timeout.
- ogrant reflects the current state combinationally.
- irst asserted mid-packet: the output packet is truncated and the FSM returns to IDLE immediately. The tx block shares the same reset.

Decomposition:
- Shared package ts_pkg: TS_SYNC=8'h47; NULL_HDR bytes {47,1F,FF,10}; PKT_LEN_DEF=188; state enum {IDLE, SRC0, SRC1, NULL}; grant encoding.
- One sub-module: ts_null_gen, which maps cnt to a byte (purely combinational).
- Counters and FSM stay in ts_packet_arbiter.

Test Plan:
- Both sources present isop at cycle 5 with irdy=1 → src0 granted; 188 bytes out, osop only on the first; then src1 packet follows back-to-back; ogrant sequence 1,0,2.
- No sources, irdy=1, NULL_EN=1 → after 16 idle cycles the output is 47 1F FF 10 followed by 184×FF, with ogrant=3.
- Src0 sends 5 bytes without isop, then a valid packet → the 5 bytes are flushed (ordy0=1, oval=0); the packet then passes intact with oerr=0.
- Src1 asserts isop at byte 100 of its packet → oerr pulses once; the packet still ends at 188 bytes.
- irdy toggled 1/0 every cycle during a null packet → exactly 188 transfers with correct byte order, and odat is stable while stalled.
- irst pulsed at byte 50 of a src0 packet → all outputs go to 0 asynchronously; after release a fresh src1 packet is granted normally.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared constants and types for the transport-stream packet arbiter.
// The state encoding doubles as the grant code seen on the grant output.
package ts_pkg;

  localparam logic [7:0]  TS_SYNC       = 8'h47;
  localparam logic [31:0] NULL_HDR      = {TS_SYNC, 24'h1FFF10};
  localparam logic [7:0]  NULL_FILL     = 8'hFF;
  localparam int          PKT_LEN_DEF   = 188;
  localparam int          NULL_WAIT_DEF = 16;

  // 0 = idle, 1 = src0, 2 = src1, 3 = null packet
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRC0 = 2'd1,
    ST_SRC1 = 2'd2,
    ST_NULL = 2'd3
  } state_e;

  function automatic logic [1:0] grant_of(input state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/ts_null_gen.sv
// Maps a byte index inside a packet to the DVB null packet byte (PID 0x1FFF).
// Purely combinational.
module ts_null_gen
  import ts_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] cnt_i,
  output logic [7:0]    byte_o
);

  always_comb begin
    byte_o = NULL_FILL;
    for (int i = 0; i < 4; i++) begin
      if (cnt_i == CW'(i)) byte_o = NULL_HDR[31-8*i -: 8];
    end
  end

endmodule

// File: rtl/ts_packet_arbiter.sv
// Packet-atomic round-robin scheduler feeding one TS byte stream from two
// sources, with resync flushing and null-packet insertion when starved.
module ts_packet_arbiter
  import ts_pkg::*;
#(
  parameter int PKT_LEN   = PKT_LEN_DEF,
  parameter int NULL_WAIT = NULL_WAIT_DEF,
  parameter bit NULL_EN   = 1'b1
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic [7:0] idat0,
  input  logic       isop0,
  input  logic       ival0,
  output logic       ordy0,
  input  logic [7:0] idat1,
  input  logic       isop1,
  input  logic       ival1,
  output logic       ordy1,
  output logic [7:0] odat,
  output logic       osop,
  output logic       oval,
  input  logic       irdy,
  output logic [1:0] ogrant,
  output logic       oerr
);

  localparam int CW = $clog2(PKT_LEN);
  localparam int IW = $clog2(NULL_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PKT_LEN - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(NULL_WAIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          ptr_q, ptr_d;   // 0 = src0 wins a tie, 1 = src1
  logic          err_q, err_d;

  logic          start0, start1;
  logic          cnt_zero, cnt_last;
  logic [7:0]    null_byte;
  logic [7:0]    s_dat;
  logic          s_sop, s_val, xfer;

  assign start0   = ival0 & isop0;
  assign start1   = ival1 & isop1;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_last = (cnt_q == CNT_LAST);

  assign s_dat = (state_q == ST_SRC1) ? idat1 : idat0;
  assign s_sop = (state_q == ST_SRC1) ? isop1 : isop0;
  assign s_val = (state_q == ST_SRC1) ? ival1 : ival0;

  ts_null_gen #(.CW(CW)) u_null_gen (
    .cnt_i  (cnt_q),
    .byte_o (null_byte)
  );

  // Handshake: a byte moves on any side exactly when its valid and ready are
  // both high at the iclk edge; valid never waits for ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = '0;
    ptr_d   = ptr_q;
    err_d   = 1'b0;
    odat    = '0;
    osop    = 1'b0;
    oval    = 1'b0;
    ordy0   = 1'b0;
    ordy1   = 1'b0;
    xfer    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Mid-packet bytes are drained so a source resyncs on its next sync byte.
        ordy0 = ival0 & ~isop0 & ~irst;
        ordy1 = ival1 & ~isop1 & ~irst;
        cnt_d = '0;
        if (start0 && start1) begin
          state_d = ptr_q ? ST_SRC1 : ST_SRC0;
        end else if (start0) begin
          state_d = ST_SRC0;
        end else if (start1) begin
          state_d = ST_SRC1;
        end else if (irdy) begin
          if (idle_q == IDLE_LAST) begin
            if (NULL_EN) state_d = ST_NULL;
            else         idle_d  = idle_q;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
      end
      ST_SRC0, ST_SRC1: begin
        odat = s_dat;
        oval = s_val;
        osop = s_sop & cnt_zero;
        xfer = s_val & irdy;
        if (state_q == ST_SRC0) ordy0 = irdy;
        else                    ordy1 = irdy;
        if (xfer && s_sop && !cnt_zero) err_d = 1'b1;
        if (xfer) begin
          if (cnt_last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ptr_d   = (state_q == ST_SRC0);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_NULL: begin
        odat = null_byte;
        oval = 1'b1;
        osop = cnt_zero;
        xfer = irdy;
        if (xfer) begin
          if (cnt_last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign ogrant = grant_of(state_q);
  assign oerr   = err_q;

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Directed bench for ts_packet_arbiter: two packet sources, a byte scoreboard
// and immediate-assertion checks.
module tb_ts_packet_arbiter;

  localparam int PKT = 188;
  localparam int W   = 11;   // {grant[1:0], sop, byte}

  logic       iclk, irst;
  logic [7:0] idat0, idat1, odat;
  logic       isop0, ival0, ordy0, isop1, ival1, ordy1;
  logic       osop, oval, irdy, oerr;
  logic [1:0] ogrant;

  ts_packet_arbiter dut (
    .iclk(iclk), .irst(irst),
    .idat0(idat0), .isop0(isop0), .ival0(ival0), .ordy0(ordy0),
    .idat1(idat1), .isop1(isop1), .ival1(ival1), .ordy1(ordy1),
    .odat(odat), .osop(osop), .oval(oval), .irdy(irdy),
    .ogrant(ogrant), .oerr(oerr)
  );

  // clock / reset
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // scoreboard and bookkeeping
  logic [W-1:0] exp_q[$];
  logic [1:0]   gtrace[$];
  int n_assert = 0, n_fail = 0;
  int n_out = 0, n_err = 0, n_flush = 0, n_stall = 0;
  int irdy_mode = 2;   // 0: held high, 1: toggling, 2: held low
  logic tog = 1'b0;
  logic chk_stall = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_odat = '0;

  // source models
  int junk[2], idx[2], len[2], bad_sop[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] src_byte(input int n, input int k);
    logic [7:0] kb;
    kb = k[7:0];
    if (k == 0) return 8'h47;
    return (n == 0) ? kb : ~kb;
  endfunction

  task automatic push_src(input int n, input int count);
    for (int k = 0; k < count; k++)
      exp_q.push_back({2'(n + 1), (k == 0), src_byte(n, k)});
  endtask

  task automatic push_null();
    logic [7:0] b;
    for (int k = 0; k < PKT; k++) begin
      case (k)
        0:       b = 8'h47;
        1:       b = 8'h1F;
        2:       b = 8'hFF;
        3:       b = 8'h10;
        default: b = 8'hFF;
      endcase
      exp_q.push_back({2'd3, (k == 0), b});
    end
  endtask

  task automatic load_src(input int n, input int nj, input int bsop);
    junk[n] = nj; idx[n] = 0; len[n] = PKT; bad_sop[n] = bsop;
  endtask

  task automatic drive_srcs();
    logic [7:0] d[2];
    logic s[2], v[2];
    for (int n = 0; n < 2; n++) begin
      if (junk[n] > 0) begin
        d[n] = 8'hEE; s[n] = 1'b0; v[n] = 1'b1;
      end else if (idx[n] < len[n]) begin
        d[n] = src_byte(n, idx[n]);
        s[n] = (idx[n] == 0) || (idx[n] == bad_sop[n]);
        v[n] = 1'b1;
      end else begin
        d[n] = 8'h00; s[n] = 1'b0; v[n] = 1'b0;
      end
    end
    idat0 = d[0]; isop0 = s[0]; ival0 = v[0];
    idat1 = d[1]; isop1 = s[1]; ival1 = v[1];
  endtask

  task automatic advance_src(input int n, input logic hs);
    if (hs) begin
      if (junk[n] > 0) begin
        junk[n]--;
        if (!oval) n_flush++;
      end else begin
        idx[n]++;
      end
    end
  endtask

  // driver: one clock cycle, inputs changed on the falling edge
  task automatic cyc();
    logic [W-1:0] e;
    @(negedge iclk);
    case (irdy_mode)
      0:       irdy = 1'b1;
      1:       begin irdy = tog; tog = ~tog; end
      default: irdy = 1'b0;
    endcase
    drive_srcs();
    #1;
    if (oerr) n_err++;
    if (gtrace.size() == 0 || ogrant !== gtrace[$]) gtrace.push_back(ogrant);
    if (chk_stall && prev_stall) begin
      chk("stall_odat", {24'd0, odat}, {24'd0, prev_odat});
      chk("stall_oval", {31'd0, oval}, 32'd1);
      n_stall++;
    end
    prev_stall = oval && !irdy;
    prev_odat  = odat;
    if (oval && irdy) begin
      n_out++;
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out: observed byte %0h expected none", odat);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_byte", {21'd0, ogrant, osop, odat}, {21'd0, e});
      end
    end
    advance_src(0, ival0 && ordy0);
    advance_src(1, ival1 && ordy1);
  endtask

  task automatic run_until_empty(input int bound);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < bound) begin
      cyc();
      c++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_odat"},   {24'd0, odat},   0);
    chk({tag, "_osop"},   {31'd0, osop},   0);
    chk({tag, "_oval"},   {31'd0, oval},   0);
    chk({tag, "_ordy0"},  {31'd0, ordy0},  0);
    chk({tag, "_ordy1"},  {31'd0, ordy1},  0);
    chk({tag, "_ogrant"}, {30'd0, ogrant}, 0);
    chk({tag, "_oerr"},   {31'd0, oerr},   0);
  endtask

  initial begin
    int c;
    irst = 1'b1; irdy = 1'b0;
    idat0 = '0; isop0 = 1'b0; ival0 = 1'b0;
    idat1 = '0; isop1 = 1'b0; ival1 = 1'b0;
    for (int n = 0; n < 2; n++) begin
      junk[n] = 0; idx[n] = 0; len[n] = 0; bad_sop[n] = -1;
    end

    // reset state
    repeat (2) @(negedge iclk);
    #1;
    chk_outputs_zero("reset");
    @(negedge iclk);
    irst = 1'b0;

    // both sources start together: src0 first, src1 back-to-back
    irdy_mode = 0;
    repeat (5) cyc();
    gtrace.delete();
    n_out = 0; n_err = 0;
    load_src(0, 0, -1);
    load_src(1, 0, -1);
    push_src(0, PKT);
    push_src(1, PKT);
    run_until_empty(1000);
    irdy_mode = 2;
    repeat (3) cyc();
    chk("rr_count", n_out, 2 * PKT);
    chk("rr_err", n_err, 0);
    chk("rr_trace_len", gtrace.size(), 5);
    if (gtrace.size() == 5)
      chk("rr_trace", {22'd0, gtrace[0], gtrace[1], gtrace[2], gtrace[3], gtrace[4]},
          {22'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0});

    // starved: null packet after 16 idle cycles
    gtrace.delete();
    n_out = 0;
    irdy_mode = 0;
    push_null();
    c = 0;
    cyc();
    while (!oval && c < 40) begin
      c++;
      cyc();
    end
    chk("null_wait", c, 16);
    run_until_empty(500);
    irdy_mode = 2;
    cyc();
    chk("null_count", n_out, PKT);
    chk("null_trace_len", gtrace.size(), 3);
    if (gtrace.size() == 3)
      chk("null_trace", {26'd0, gtrace[0], gtrace[1], gtrace[2]}, {26'd0, 2'd0, 2'd3, 2'd0});

    // resync flush: 5 stray bytes ahead of a real packet on src0
    n_out = 0; n_err = 0; n_flush = 0;
    irdy_mode = 0;
    load_src(0, 5, -1);
    push_src(0, PKT);
    run_until_empty(600);
    irdy_mode = 2;
    repeat (2) cyc();
    chk("flush_count", n_flush, 5);
    chk("flush_out", n_out, PKT);
    chk("flush_err", n_err, 0);

    // stray sop at byte 100 of a src1 packet
    n_out = 0; n_err = 0;
    irdy_mode = 0;
    load_src(1, 0, 100);
    push_src(1, PKT);
    run_until_empty(600);
    irdy_mode = 2;
    repeat (2) cyc();
    chk("badsop_err", n_err, 1);
    chk("badsop_out", n_out, PKT);
    bad_sop[1] = -1;

    // null packet under toggling backpressure
    n_out = 0; n_stall = 0;
    chk_stall = 1'b1;
    irdy_mode = 0;
    push_null();
    c = 0;
    cyc();
    while (!oval && c < 40) begin
      c++;
      cyc();
    end
    chk("bp_null_wait", c, 16);
    irdy_mode = 1; tog = 1'b0;
    run_until_empty(1000);
    irdy_mode = 2;
    cyc();
    chk_stall = 1'b0;
    chk("bp_count", n_out, PKT);
    chk("bp_stalls", n_stall, PKT - 1);

    // reset mid-packet, then a fresh src1 packet
    n_out = 0; n_err = 0;
    irdy_mode = 0;
    load_src(0, 0, -1);
    push_src(0, 50);
    run_until_empty(200);
    chk("pre_rst_out", n_out, 50);
    @(negedge iclk);
    irst = 1'b1;
    drive_srcs();
    #1;
    chk_outputs_zero("midrst");
    len[0] = 0; idx[0] = 0;
    drive_srcs();
    repeat (2) @(negedge iclk);
    irst = 1'b0;
    n_out = 0;
    gtrace.delete();
    load_src(1, 0, -1);
    push_src(1, PKT);
    run_until_empty(600);
    irdy_mode = 2;
    repeat (2) cyc();
    chk("post_rst_out", n_out, PKT);
    chk("post_rst_err", n_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
